// File: rtl/return_addr_stack.sv
// Return address stack for the fetch stage.
// Calls (jal/jalr) push their link address. Returns pop a registered target
// prediction one cycle later. Per-fetch checkpoints of the top-of-stack state
// are exported, and a restore port rebuilds that state after a redirect.
module return_addr_stack #(
  parameter int LG_DEPTH = 3,
  parameter int ADDR_W   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid,
  input  logic [2:0]          fetch_pd,
  input  logic [ADDR_W-1:0]   fetch_pc,
  output logic                ret_valid,
  output logic [ADDR_W-1:0]   ret_addr,
  output logic [LG_DEPTH-1:0] ckpt_ptr,
  output logic [LG_DEPTH:0]   ckpt_cnt,
  output logic [ADDR_W-1:0]   ckpt_top,
  input  logic                restore_valid,
  input  logic [LG_DEPTH-1:0] restore_ptr,
  input  logic [LG_DEPTH:0]   restore_cnt,
  input  logic [ADDR_W-1:0]   restore_top
);

  localparam int DEPTH = 1 << LG_DEPTH;
  localparam logic [LG_DEPTH:0] FULL_CNT = (LG_DEPTH + 1)'(DEPTH);

  // Predecode classes that touch the stack
  localparam logic [2:0] PD_RET  = 3'd2;
  localparam logic [2:0] PD_JAL  = 3'd5;
  localparam logic [2:0] PD_JALR = 3'd6;

  logic [LG_DEPTH-1:0] tos;
  logic [LG_DEPTH:0]   cnt;
  logic [ADDR_W-1:0]   mem [DEPTH];

  logic                is_push;
  logic                is_pop;
  logic [LG_DEPTH-1:0] tos_inc;
  logic [LG_DEPTH-1:0] tos_dec;
  logic [LG_DEPTH:0]   restore_cnt_clamped;

  // A restore takes the cycle, so any fetch op alongside it is dropped
  assign is_push = fetch_valid && !restore_valid &&
                   ((fetch_pd == PD_JAL) || (fetch_pd == PD_JALR));
  assign is_pop  = fetch_valid && !restore_valid && (fetch_pd == PD_RET);

  assign tos_inc = tos + LG_DEPTH'(1);
  assign tos_dec = tos - LG_DEPTH'(1);

  assign restore_cnt_clamped = (restore_cnt > FULL_CNT) ? FULL_CNT : restore_cnt;

  // Checkpoints show the state as it stands before this cycle's update
  assign ckpt_ptr = tos;
  assign ckpt_cnt = cnt;
  assign ckpt_top = mem[tos];

  // Pointer, occupancy and registered prediction
  always_ff @(posedge clk) begin
    if (reset) begin
      tos       <= '0;
      cnt       <= '0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
    end else if (restore_valid) begin
      tos       <= restore_ptr;
      cnt       <= restore_cnt_clamped;
      ret_valid <= 1'b0;
    end else if (is_push) begin
      tos       <= tos_inc;
      ret_valid <= 1'b0;
      if (cnt != FULL_CNT) begin
        cnt <= cnt + (LG_DEPTH + 1)'(1);
      end
    end else if (is_pop && (cnt != '0)) begin
      tos       <= tos_dec;
      cnt       <= cnt - (LG_DEPTH + 1)'(1);
      ret_valid <= 1'b1;
      ret_addr  <= mem[tos];
    end else begin
      ret_valid <= 1'b0;
    end
  end

  // Entry storage, deliberately not reset; a full push overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (restore_valid) begin
        mem[restore_ptr] <= restore_top;
      end else if (is_push) begin
        mem[tos_inc] <= fetch_pc + ADDR_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: directed vectors with hand-computed results.
// Every driven cycle queues the outputs expected after the next clock edge;
// a monitor pops one entry per edge and compares.
module tb_return_addr_stack;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [2:0]  fetch_pd;
  logic [63:0] fetch_pc;
  logic        ret_valid;
  logic [63:0] ret_addr;
  logic [2:0]  ckpt_ptr;
  logic [3:0]  ckpt_cnt;
  logic [63:0] ckpt_top;
  logic        restore_valid;
  logic [2:0]  restore_ptr;
  logic [3:0]  restore_cnt;
  logic [63:0] restore_top;

  typedef struct {
    logic        valid;
    logic [63:0] addr;
    logic        chk_addr;
    logic [3:0]  cnt;
    logic [2:0]  ptr;
    logic [63:0] top;
    logic        chk_top;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  return_addr_stack #(.LG_DEPTH(3), .ADDR_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_pd     (fetch_pd),
    .fetch_pc     (fetch_pc),
    .ret_valid    (ret_valid),
    .ret_addr     (ret_addr),
    .ckpt_ptr     (ckpt_ptr),
    .ckpt_cnt     (ckpt_cnt),
    .ckpt_top     (ckpt_top),
    .restore_valid(restore_valid),
    .restore_ptr  (restore_ptr),
    .restore_cnt  (restore_cnt),
    .restore_top  (restore_top)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input logic [63:0] a, input logic ca,
                              input logic [3:0] c, input logic [2:0] p,
                              input logic [63:0] t, input logic ct);
    exp_t e;
    e.valid    = v;
    e.addr     = a;
    e.chk_addr = ca;
    e.cnt      = c;
    e.ptr      = p;
    e.top      = t;
    e.chk_top  = ct;
    return e;
  endfunction

  // Compare the outputs settled after a clock edge against one queued expectation
  task automatic checkOutput(input exp_t e);
    checks++;
    if (ret_valid !== e.valid) begin
      errors++;
      $display("[TB] FAIL ret_valid got %0b want %0b at %0t", ret_valid, e.valid, $time);
    end
    if (e.chk_addr) begin
      checks++;
      if (ret_addr !== e.addr) begin
        errors++;
        $display("[TB] FAIL ret_addr got %h want %h at %0t", ret_addr, e.addr, $time);
      end
    end
    checks++;
    if (ckpt_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL ckpt_cnt got %0d want %0d at %0t", ckpt_cnt, e.cnt, $time);
    end
    checks++;
    if (ckpt_ptr !== e.ptr) begin
      errors++;
      $display("[TB] FAIL ckpt_ptr got %0d want %0d at %0t", ckpt_ptr, e.ptr, $time);
    end
    if (e.chk_top) begin
      checks++;
      if (ckpt_top !== e.top) begin
        errors++;
        $display("[TB] FAIL ckpt_top got %h want %h at %0t", ckpt_top, e.top, $time);
      end
    end
  endtask

  // Monitor: one expectation consumed per clock edge that followed a driven cycle
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  // Drive one cycle of inputs and queue what the DUT should show after the edge
  task automatic applyStimulus(input logic rst, input logic fv, input logic [2:0] pd,
                               input logic [63:0] pc, input logic rv, input logic [2:0] rp,
                               input logic [3:0] rc, input logic [63:0] rt, input exp_t e);
    @(negedge clk);
    reset         = rst;
    fetch_valid   = fv;
    fetch_pd      = pd;
    fetch_pc      = pc;
    restore_valid = rv;
    restore_ptr   = rp;
    restore_cnt   = rc;
    restore_top   = rt;
    exp_q.push_back(e);
  endtask

  task automatic doFetch(input logic fv, input logic [2:0] pd, input logic [63:0] pc,
                         input exp_t e);
    applyStimulus(1'b0, fv, pd, pc, 1'b0, 3'd0, 4'd0, 64'd0, e);
  endtask

  task automatic doReset(input logic [2:0] pd, input exp_t e);
    applyStimulus(1'b1, 1'b1, pd, 64'h0, 1'b0, 3'd0, 4'd0, 64'd0, e);
  endtask

  task automatic doRestore(input logic [2:0] pd, input logic [2:0] rp, input logic [3:0] rc,
                           input logic [63:0] rt, input exp_t e);
    applyStimulus(1'b0, 1'b1, pd, 64'h0, 1'b1, rp, rc, rt, e);
  endtask

  // Watchdog so a stuck run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence
  initial begin
    reset         = 1'b1;
    fetch_valid   = 1'b0;
    fetch_pd      = 3'd0;
    fetch_pc      = 64'h0;
    restore_valid = 1'b0;
    restore_ptr   = 3'd0;
    restore_cnt   = 4'd0;
    restore_top   = 64'h0;

    // 1: reset state, then pop on empty stack misses and ret_addr holds 0
    doReset(3'd0, mk(1'b0, 64'h0, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));
    doFetch(1'b1, 3'd2, 64'h0, mk(1'b0, 64'h0, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));

    // 2: single call/return pair
    doFetch(1'b1, 3'd5, 64'h1000, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h1004, 1'b1));
    doFetch(1'b1, 3'd2, 64'h0, mk(1'b1, 64'h1004, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));
    doFetch(1'b1, 3'd0, 64'h0, mk(1'b0, 64'h0, 1'b0, 4'd0, 3'd0, 64'h0, 1'b0));

    // 3: overflow by one, drain with back-to-back pops, final pop misses
    for (int i = 1; i <= 9; i++) begin
      doFetch(1'b1, 3'd5, 64'(i) * 64'h100,
              mk(1'b0, 64'h0, 1'b0, (i >= 8) ? 4'd8 : 4'(i), 3'(i % 8),
                 64'(i) * 64'h100 + 64'h4, 1'b1));
    end
    for (int k = 0; k < 8; k++) begin
      doFetch(1'b1, 3'd2, 64'h0,
              mk(1'b1, 64'(9 - k) * 64'h100 + 64'h4, 1'b1, 4'(7 - k), 3'((8 - k) % 8),
                 64'h0, 1'b0));
    end
    doFetch(1'b1, 3'd2, 64'h0, mk(1'b0, 64'h204, 1'b1, 4'd0, 3'd1, 64'h0, 1'b0));

    // 4: restore wins over a same-cycle pop
    doReset(3'd0, mk(1'b0, 64'h0, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));
    doFetch(1'b1, 3'd5, 64'h2000, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h2004, 1'b1));
    doFetch(1'b1, 3'd6, 64'h3000, mk(1'b0, 64'h0, 1'b0, 4'd2, 3'd2, 64'h3004, 1'b1));
    doRestore(3'd2, 3'd1, 4'd1, 64'h2004, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h2004, 1'b1));
    doFetch(1'b1, 3'd2, 64'h0, mk(1'b1, 64'h2004, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));
    // Restore writes a fresh value and clamps an oversized count
    doRestore(3'd5, 3'd5, 4'd12, 64'hABC0, mk(1'b0, 64'h0, 1'b0, 4'd8, 3'd5, 64'hABC0, 1'b1));
    doFetch(1'b1, 3'd2, 64'h0, mk(1'b1, 64'hABC0, 1'b1, 4'd7, 3'd4, 64'h0, 1'b0));

    // 5: link address wraps around; non-stack classes and invalid fetches do nothing
    doReset(3'd0, mk(1'b0, 64'h0, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));
    doFetch(1'b1, 3'd6, 64'hFFFF_FFFF_FFFF_FFFC, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h0, 1'b1));
    doFetch(1'b1, 3'd4, 64'h4000, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h0, 1'b1));
    doFetch(1'b0, 3'd5, 64'h5000, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h0, 1'b1));
    doFetch(1'b0, 3'd2, 64'h0, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h0, 1'b1));
    doFetch(1'b1, 3'd7, 64'h6000, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h0, 1'b1));
    doFetch(1'b1, 3'd2, 64'h0, mk(1'b1, 64'h0, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));

    // 6: reset right after a pop, and reset on the same cycle as a pop
    doFetch(1'b1, 3'd5, 64'h500, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h504, 1'b1));
    doFetch(1'b1, 3'd2, 64'h0, mk(1'b1, 64'h504, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));
    doReset(3'd2, mk(1'b0, 64'h0, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));
    doFetch(1'b1, 3'd5, 64'h600, mk(1'b0, 64'h0, 1'b0, 4'd1, 3'd1, 64'h604, 1'b1));
    doReset(3'd2, mk(1'b0, 64'h0, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));
    doFetch(1'b1, 3'd0, 64'h0, mk(1'b0, 64'h0, 1'b1, 4'd0, 3'd0, 64'h0, 1'b0));

    // Let the monitor drain, then make sure nothing was left unchecked
    @(negedge clk);
    fetch_valid = 1'b0;
    reset       = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
